// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
package rr_arbiter4_pkg;

   localparam int NREQ  = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   // Result of the round-robin search: whether anyone is requesting, and who wins.
   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } rr_pick_t;

endpackage

// File: rtl/rr_arbiter4_decode24.sv
// 2-to-4 one-hot decoder used to turn the owner index into a grant vector.
module rr_arbiter4_decode24
   import rr_arbiter4_pkg::*;
(
   input  logic [IDX_W-1:0] sel,
   output logic [NREQ-1:0]  onehot
);

   // Exactly one output bit follows the selected index.
   always_comb begin
      onehot      = '0;
      onehot[sel] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters with a per-tenure hold limit.
//
//  state    | meaning
//  ---------+----------------------------------------------------------------
//  ARB_IDLE | no tenure; arbitrate on req, search starts after last owner
//  ARB_BUSY | owner holds the resource until it drops req or hits MAX_HOLD
//
// Every release passes through ARB_IDLE, which gives one grant-free
// turnaround cycle between tenures.
module rr_arbiter4
   import rr_arbiter4_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
)
(
   input  logic              CLK,
   input  logic              Reset,
   input  logic [NREQ-1:0]   req,
   output logic [NREQ-1:0]   grant,
   output logic              grant_valid,
   output logic [IDX_W-1:0]  owner,
   output logic              expire
);

   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] CNT_TOP  = '1;
   // With no hold limit the counter simply parks at its top value.
   localparam logic [HOLD_W-1:0] CNT_SAT  = (MAX_HOLD == 0) ? CNT_TOP : HOLD_LIM;

   arb_state_t        state;
   logic [IDX_W-1:0]  last_owner;
   logic [HOLD_W-1:0] hold_cnt;
   rr_pick_t          pick;
   logic              owner_req;
   logic              timeout;
   logic [NREQ-1:0]   dec_onehot;

   // First requester found scanning last+1, last+2, ... modulo NREQ.
   function automatic rr_pick_t rr_next(input logic [IDX_W-1:0] last,
                                        input logic [NREQ-1:0]  reqs);
      rr_pick_t         res;
      logic [IDX_W-1:0] cand;
      res = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = last + IDX_W'(k);
         if (!res.found && reqs[cand]) begin
            res.found = 1'b1;
            res.idx   = cand;
         end
      end
      return res;
   endfunction

   assign pick      = rr_next(last_owner, req);
   assign owner_req = req[owner];
   assign timeout   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);

   rr_arbiter4_decode24 u_decode (
      .sel    (owner),
      .onehot (dec_onehot)
   );

   assign grant = grant_valid ? dec_onehot : '0;

   // Arbitration FSM; all outputs except the decoded grant are registered here.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state       <= ARB_IDLE;
         grant_valid <= 1'b0;
         owner       <= '0;
         expire      <= 1'b0;
         last_owner  <= IDX_W'(NREQ - 1);
         hold_cnt    <= '0;
      end else begin
         expire <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (pick.found) begin
                  state       <= ARB_BUSY;
                  owner       <= pick.idx;
                  grant_valid <= 1'b1;
                  hold_cnt    <= HOLD_W'(1);
               end
            end
            ARB_BUSY: begin
               // A dropped request takes priority over the timeout, so no expire pulse.
               if (!owner_req) begin
                  state       <= ARB_IDLE;
                  grant_valid <= 1'b0;
                  last_owner  <= owner;
               end else if (timeout) begin
                  state       <= ARB_IDLE;
                  grant_valid <= 1'b0;
                  last_owner  <= owner;
                  expire      <= 1'b1;
               end else if (hold_cnt != CNT_SAT) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state       <= ARB_IDLE;
               grant_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
